// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_cap(input int depth);
        return 1 << depth;
    endfunction

    // Almost-full must be reachable and non-zero; almost-empty must sit below capacity.
    function automatic bit fifo_thresh_ok(input int depth, input int af, input int ae);
        return (af > 0) && (af <= fifo_cap(depth)) && (ae >= 0) && (ae < fifo_cap(depth));
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Simple dual-port RAM: synchronous write, registered read (read-first on collision).
module fifo_sync_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [DEPTH-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register is reset so the FIFO's read data is defined out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read, fill level,
// programmable almost flags, synchronous flush and sticky overflow/underflow.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = 2**DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_Flush,
    input  logic             i_Clr_Err,
    input  logic             i_WR_En,
    input  logic [WIDTH-1:0] i_WR_Data,
    input  logic             i_RD_En,
    output logic [WIDTH-1:0] o_RD_Data,
    output logic             o_RD_Valid,
    output logic             o_Full,
    output logic             o_Empty,
    output logic             o_Almost_Full,
    output logic             o_Almost_Empty,
    output logic [DEPTH:0]   o_Count,
    output logic             o_Overflow,
    output logic             o_Underflow
);

    localparam int             CAP  = fifo_cap(DEPTH);
    localparam logic [DEPTH:0] CAP_C = CAP[DEPTH:0];
    localparam logic [DEPTH:0] AF_C  = AF_THRESH[DEPTH:0];
    localparam logic [DEPTH:0] AE_C  = AE_THRESH[DEPTH:0];
    localparam logic [DEPTH:0] ONE   = {{DEPTH{1'b0}}, 1'b1};

    if (!fifo_thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("fifo_sync_flags: illegal AF_THRESH/AE_THRESH for this DEPTH");
    end

    logic [DEPTH:0]   wr_ptr, rd_ptr, count;
    logic [DEPTH:0]   wr_ptr_next, rd_ptr_next, count_next;
    logic             wr_acc, rd_acc;
    logic             mem_rd_en;
    logic [DEPTH-1:0] mem_rd_addr;
    logic [WIDTH-1:0] mem_q;

    // Handshake: a write is taken when i_WR_En is high and the FIFO is not full,
    // a read when i_RD_En is high and it is not empty; flush blocks both.
    assign wr_acc = i_WR_En & ~o_Full  & ~i_Flush;
    assign rd_acc = i_RD_En & ~o_Empty & ~i_Flush;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (i_Flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_acc) wr_ptr_next = wr_ptr + ONE;
            if (rd_acc) rd_ptr_next = rd_ptr + ONE;
            count_next = count + {{DEPTH{1'b0}}, wr_acc} - {{DEPTH{1'b0}}, rd_acc};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            o_Full         <= 1'b0;
            o_Empty        <= 1'b1;
            o_Almost_Full  <= 1'b0;
            o_Almost_Empty <= 1'b1;
            o_Overflow     <= 1'b0;
            o_Underflow    <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_next;
            rd_ptr         <= rd_ptr_next;
            count          <= count_next;
            o_Full         <= (count_next == CAP_C);
            o_Empty        <= (count_next == '0);
            o_Almost_Full  <= (count_next >= AF_C);
            o_Almost_Empty <= (count_next <= AE_C);
            // Setting beats clearing when both happen in one cycle.
            if (i_WR_En & o_Full & ~i_Flush)       o_Overflow <= 1'b1;
            else if (i_Clr_Err)                    o_Overflow <= 1'b0;
            if (i_RD_En & o_Empty & ~i_Flush)      o_Underflow <= 1'b1;
            else if (i_Clr_Err)                    o_Underflow <= 1'b0;
        end
    end

    assign o_Count = count;

    fifo_sync_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[DEPTH-1:0]),
        .wr_data (i_WR_Data),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_q)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        logic             byp_sel;
        logic [WIDTH-1:0] byp_data;

        // The RAM continuously prefetches the next head; a write landing on that
        // slot in the same cycle is not visible to the RAM read, so it is bypassed.
        assign mem_rd_en   = 1'b1;
        assign mem_rd_addr = rd_ptr_next[DEPTH-1:0];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                byp_sel  <= 1'b0;
                byp_data <= '0;
            end else begin
                byp_sel <= wr_acc && (wr_ptr == rd_ptr_next);
                if (wr_acc && (wr_ptr == rd_ptr_next)) byp_data <= i_WR_Data;
            end
        end

        assign o_RD_Data  = byp_sel ? byp_data : mem_q;
        assign o_RD_Valid = ~o_Empty;
    end else begin : g_std
        logic valid_q;

        assign mem_rd_en   = rd_acc;
        assign mem_rd_addr = rd_ptr[DEPTH-1:0];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) valid_q <= 1'b0;
            else       valid_q <= rd_acc;
        end

        assign o_RD_Data  = mem_q;
        assign o_RD_Valid = valid_q;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO; used where producer and consumer share a clock.
- Adds:
  - selectable standard or first-word-fall-through (FWFT) read mode
  - fill-level output
  - programmable almost-full/almost-empty thresholds
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between a streaming producer and consumer inside one clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, address width; capacity CAP = 2**DEPTH words.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- AF_THRESH, 2**DEPTH-1, o_Almost_Full asserts when count >= AF_THRESH.
- AE_THRESH, 1, o_Almost_Empty asserts when count <= AE_THRESH.

Ports:
- i_clk  input  1  sole clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_Flush  input  1  synchronous clear of FIFO contents.
- i_Clr_Err  input  1  clears sticky error flags.
- i_WR_En  input  1  write request.
- i_WR_Data  input  WIDTH  write data.
- i_RD_En  input  1  read request; in FWFT mode this is the pop/acknowledge.
- o_RD_Data  output  WIDTH  read data.
- o_RD_Valid  output  1  standard mode: 1-cycle pulse, data valid; FWFT mode: head word present.
- o_Full  output  1  count == CAP.
- o_Empty  output  1  count == 0.
- o_Almost_Full  output  1  count >= AF_THRESH.
- o_Almost_Empty  output  1  count <= AE_THRESH.
- o_Count  output  DEPTH+1  words held; FWFT count includes the output-stage word.
- o_Overflow  output  1  sticky: write attempted while full.
- o_Underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (async assert, sync release):
  - pointers = 0, count = 0, o_Empty = 1, o_Almost_Empty = 1, o_Full = 0, o_Almost_Full = 0 (AF_THRESH > 0 required).
  - o_RD_Valid = 0, o_RD_Data = 0, o_Overflow = 0, o_Underflow = 0.
- Pointers: DEPTH+1 bits, binary, wrap naturally modulo 2**(DEPTH+1); the MSB distinguishes full from empty.
- Accept rules:
  - wr_acc = i_WR_En & ~o_Full.
  - rd_acc = i_RD_En & ~o_Empty.
- Count update: count_next = count + wr_acc - rd_acc.
  - Simultaneous accepted write and read leaves count unchanged.
  - Write while full is rejected even if a read occurs in the same cycle.
  - Read while empty is rejected even if a write occurs in the same cycle.
- All flags and o_Count are registered, computed from count_next, and valid the same cycle as the updated count.
- Standard mode (FWFT = 0):
  - On rd_acc, o_RD_Data is loaded from memory at the read pointer on the next edge, and o_RD_Valid pulses high for exactly that cycle.
  - Read latency is 1 cycle; o_RD_Data holds its value otherwise.
- FWFT mode (FWFT = 1):
  - Output stage register holds the head word; o_RD_Valid = ~o_Empty.
  - A write into an empty FIFO appears on o_RD_Data with o_RD_Valid = 1 on the next cycle.
  - On rd_acc, the next word, or a same-cycle bypass write when memory is empty, loads into the output stage on that edge.
  - Total capacity stays CAP: memory plus output stage never exceed CAP.
- Errors:
  - o_Overflow is set on i_WR_En & o_Full; o_Underflow is set on i_RD_En & o_Empty.
  - Both stay set until i_Clr_Err. If a set condition and i_Clr_Err occur in the same cycle, set wins.
- Flush:
  - Next edge: pointers = 0, count = 0, o_RD_Valid = 0, flags return to reset values; error flags are unaffected.
  - Flush overrides same-cycle write and read; neither is accepted and no error is flagged.
  - Memory contents are not cleared.
- Memory: written on wr_acc at wr_ptr[DEPTH-1:0]; read synchronously.
- Reset mid-operation: immediate return to reset state; any in-flight read-data pulse is discarded.

Decomposition:
- Package fifo_pkg holds:
  - FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1
  - function for capacity 2**DEPTH
  - threshold legality check: 0 < AF_THRESH <= CAP and AE_THRESH < CAP.
- One sub-module, fifo_sync_mem: 2**DEPTH x WIDTH simple dual-port RAM with synchronous write and synchronous registered read.
- Pointer, count, flag and FWFT output-stage logic stays in the top block.

Test Plan:
- All directed scenarios use WIDTH = 8, DEPTH = 2 (CAP = 4), AF_THRESH = 3, AE_THRESH = 1.
- FWFT = 0, fill:
  - Stimulus: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Response: o_Count goes 1, 2, 3, 4; o_Almost_Empty drops after the 2nd write; o_Almost_Full rises after the 3rd; o_Full rises after the 4th; a 5th write of 0x55 sets o_Overflow with count staying 4.
- FWFT = 0, drain:
  - Stimulus: 4 reads from full.
  - Response: o_RD_Valid pulses 1 cycle after each read with 0x11, 0x22, 0x33, 0x44; o_Empty = 1 after the last; a 5th read sets o_Underflow; i_Clr_Err clears both error flags.
- Simultaneous access:
  - Stimulus: with count = 2, assert write 0xA5 and read in the same cycle for 6 cycles.
  - Response: count stays 2; data order is preserved; the pointers wrap past index 3 correctly.
- Full plus simultaneous read:
  - Stimulus: with count = 4, assert i_WR_En and i_RD_En together.
  - Response: read accepted, write rejected, count = 3, o_Overflow = 1.
- FWFT = 1:
  - Stimulus: write 0x7E into an empty FIFO.
  - Response: next cycle o_RD_Valid = 1, o_RD_Data = 0x7E, o_Count = 1. Pop together with write 0x81 -> next cycle o_RD_Data = 0x81, count = 1.
- Flush and reset:
  - Stimulus: with count = 3, assert i_Flush together with i_WR_En.
  - Response: next cycle count = 0, o_Empty = 1, o_RD_Valid = 0, o_Overflow unchanged.
  - Stimulus: assert i_rst asynchronously mid-burst.
  - Response: all outputs reach reset values before the next clock edge.
